// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_BR,
        PC_SEL_JMP,
        PC_SEL_RET
    } pc_sel_t;

    localparam int PC_WIDTH_DEF     = 32;
    localparam int PC_STEP_DEF      = 4;
    localparam int PC_RESET_VEC_DEF = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, swap (push+pop), occupancy count
// and registered overflow/underflow pulses.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic             empty;
    logic             full;
    logic             swap;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign swap    = push && pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (swap) begin
                ptr <= ptr;
            end else if (push) begin
                // when full the oldest slot is the one ptr now points at
                ptr <= ptr + PW'(1);
                if (full)
                    overflow <= 1'b1;
                else
                    count <= count + CW'(1);
            end else if (pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    ptr   <= top_idx;
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (swap)
            mem[top_idx] <= push_data;
        else if (push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/ret redirects; the return-address
// stack is compiled in only when PC_UNIT_RAS_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF),
    parameter int               STEP      = PC_STEP_DEF,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch,
    input  logic [WIDTH-1:0]             branch_target,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             jump_target,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    pc_sel_t          sel;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;

    assign pc_plus = pc + WIDTH'(STEP);

`ifdef PC_UNIT_RAS_EN
    logic ras_valid;

    assign ras_valid = (ras_count != '0);
    assign ras_push  = call && !stall;
    assign ras_pop   = ret && !stall;

    always_comb begin
        sel = PC_SEL_SEQ;
        if (ret && ras_valid)
            sel = PC_SEL_RET;
        else if (ret && !call)
            sel = PC_SEL_SEQ;
        else if (call || jump)
            sel = PC_SEL_JMP;
        else if (branch)
            sel = PC_SEL_BR;
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );
`else
    logic unused_ret;

    assign unused_ret    = ret;
    assign ras_push      = 1'b0;
    assign ras_pop       = 1'b0;
    assign ras_top       = '0;
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;

    always_comb begin
        sel = PC_SEL_SEQ;
        if (call || jump)
            sel = PC_SEL_JMP;
        else if (branch)
            sel = PC_SEL_BR;
    end
`endif

    always_comb begin
        next_pc = pc_plus;
        case (sel)
            PC_SEL_BR:  next_pc = branch_target;
            PC_SEL_JMP: next_pc = jump_target;
            PC_SEL_RET: next_pc = ras_top;
            default:    next_pc = pc_plus;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_VEC;
        else if (!stall)
            pc <= next_pc;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (WIDTH=8, STEP=1, RESET_VEC=0x10).
module tb_pc_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic       stall;
        logic       branch;
        logic       jump;
        logic       call;
        logic       ret;
        logic [7:0] bt;
        logic [7:0] jt;
        logic [7:0] exp_pc;
        logic [2:0] exp_cnt;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       branch = 1'b0;
    logic [7:0] branch_target = '0;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] jump_target = '0;
    logic [7:0] pc;
    logic [7:0] pc_plus;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    pc_unit #(
        .WIDTH     (WIDTH),
        .RESET_VEC (8'h10),
        .STEP      (1),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic j,
                       input logic c, input logic r, input logic [7:0] bt,
                       input logic [7:0] jt, input logic [7:0] p,
                       input logic [2:0] n, input logic o, input logic u);
        vec_t v;
        v.stall = s; v.branch = b; v.jump = j; v.call = c; v.ret = r;
        v.bt = bt; v.jt = jt; v.exp_pc = p; v.exp_cnt = n;
        v.exp_ovf = o; v.exp_unf = u;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic s, input logic b, input logic j,
                         input logic c, input logic r, input logic [7:0] bt,
                         input logic [7:0] jt);
        stall = s; branch = b; jump = j; call = c; ret = r;
        branch_target = bt; jump_target = jt;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] p,
                             input logic [2:0] n, input logic o,
                             input logic u);
        chk({tag, ".pc"}, 32'(pc), 32'(p));
        chk({tag, ".pc_plus"}, 32'(pc_plus), 32'(8'(p + 8'd1)));
        chk({tag, ".ras_count"}, 32'(ras_count), 32'(n));
        chk({tag, ".ovf"}, 32'(ras_overflow), 32'(o));
        chk({tag, ".unf"}, 32'(ras_underflow), 32'(u));
    endtask

    initial begin
        // s  b  j  c  r  bt     jt     pc     cnt ovf unf
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h12, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h13, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'hFF, 8'hFF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 1, 0, 0, 8'h77, 8'h66, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 8'h80, 8'h40, 8'h40, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0, 0);
`ifdef PC_UNIT_RAS_EN
        add(0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h50, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h02, 8'h02, 1, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h03, 8'h03, 2, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h04, 8'h04, 3, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 4, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h06, 8'h06, 4, 1, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h06, 3, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h05, 2, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h04, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h03, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h04, 0, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h30, 8'h30, 0, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h60, 8'h60, 1, 0, 0);
        add(0, 0, 0, 1, 1, 8'h00, 8'h77, 8'h31, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h61, 0, 0, 0);
        add(0, 0, 0, 1, 1, 8'h00, 8'h90, 8'h90, 1, 0, 0);
        add(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h90, 1, 0, 0);
        add(1, 0, 0, 1, 0, 8'h00, 8'h44, 8'h90, 1, 0, 0);
        add(0, 1, 1, 0, 1, 8'h55, 8'hAA, 8'h62, 0, 0, 0);
        add(0, 1, 0, 0, 1, 8'h33, 8'h00, 8'h63, 0, 0, 1);
        add(0, 0, 0, 1, 0, 8'h00, 8'h70, 8'h70, 1, 0, 0);
`else
        add(0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h51, 0, 0, 0);
        add(0, 0, 0, 1, 1, 8'h00, 8'h60, 8'h60, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h61, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h80, 8'h70, 8'h70, 0, 0, 0);
`endif

        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
        repeat (2) step();
        chk_state("reset", 8'h10, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].branch, tbl[i].jump, tbl[i].call,
                  tbl[i].ret, tbl[i].bt, tbl[i].jt);
            step();
            chk_state($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_cnt,
                      tbl[i].exp_ovf, tbl[i].exp_unf);
        end

        // asynchronous reset mid-count, no clock edge in between
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
        step();
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 8'h10, 0, 0, 0);

        // reset wins over stall and redirects
        drive(1, 1, 1, 1, 1, 8'h99, 8'h88);
        step();
        chk_state("rst_stall", 8'h10, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        step();
        chk_state("post_rst", 8'h11, 0, 0, 0);

        // reset during stall mid-operation
        stall = 1'b1;
        step();
        #1 rst = 1'b1;
        #1;
        chk_state("rst_in_stall", 8'h10, 0, 0, 0);
        step();
        rst = 1'b0;
        stall = 1'b0;
        drive(0, 0, 1, 0, 0, 8'h00, 8'h3C);
        step();
        chk_state("first_edge", 8'h3C, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 0, value loaded into pc on reset.
- STEP, 4, sequential increment.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all state.
- branch  in  1  take branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  take jump_target.
- call  in  1  jump to jump_target and push return address.
- ret  in  1  pop return address into pc.
- jump_target  in  WIDTH  jump/call destination.
- pc  out  WIDTH  registered current PC.
- pc_plus  out  WIDTH  combinational pc+STEP.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- ras_overflow  out  1  registered one-cycle pulse.
- ras_underflow  out  1  registered one-cycle pulse.

Function
REQ-003 pc_plus SHALL equal (pc+STEP) mod 2^WIDTH; wrap-around is silent.
REQ-004 The next-PC priority SHALL be: stall > ret > call > jump > branch > sequential (pc_plus).
REQ-005 While stall=1, pc, the stack, ras_count and the pointer SHALL hold; both pulse outputs SHALL be 0.
REQ-006 Any redirect SHALL take effect in pc on the edge where it is sampled, i.e. 1-cycle latency, with no bubble.
REQ-007 On call, pc SHALL load jump_target and pc_plus SHALL be pushed.
REQ-008 On a call while ras_count=RAS_DEPTH, the oldest entry SHALL be overwritten (circular), ras_count SHALL stay at RAS_DEPTH, and ras_overflow SHALL pulse on the next cycle.
REQ-009 On ret with ras_count>0, pc SHALL load the top entry and ras_count SHALL decrement.
REQ-010 On ret with ras_count=0, pc SHALL load pc_plus, the stack SHALL remain unchanged, and ras_underflow SHALL pulse.
REQ-011 On simultaneous call and ret with ras_count>0 (swap), pc SHALL load the top entry, the top SHALL be replaced by pc_plus, and ras_count SHALL be unchanged.
REQ-012 On simultaneous call and ret with ras_count=0, the block SHALL behave as a plain call.
REQ-013 Without call or ret, branch and jump SHALL NOT modify the stack.

Reset
REQ-014 While rst=1, asynchronously:
- pc SHALL be RESET_VEC.
- ras_count and the stack pointer SHALL be 0.
- ras_overflow and ras_underflow SHALL be 0.
- Stack contents SHALL be don't-care.
REQ-015 Reset asserted mid-operation, including during stall, SHALL override all other inputs.
REQ-016 On the first edge after rst deasserts, normal priority SHALL apply.

Configuration
REQ-017 The macro PC_UNIT_RAS_EN SHALL compile in the return-address stack.
REQ-018 When PC_UNIT_RAS_EN is undefined:
- call SHALL act as jump.
- ret SHALL be ignored (sequential).
- ras_count, ras_overflow and ras_underflow SHALL be tied to 0.
- No stack storage SHALL be inferred.

Structure
REQ-019 Shared package pc_pkg SHALL hold:
- enum pc_sel_t {PC_SEL_SEQ, PC_SEL_BR, PC_SEL_JMP, PC_SEL_RET}.
- Default constants PC_WIDTH_DEF, PC_STEP_DEF, PC_RESET_VEC_DEF.
REQ-020 The stack SHALL be a sub-module pc_ras (push/pop/swap, count, top, overflow/underflow) instantiated only under PC_UNIT_RAS_EN.
REQ-021 Next-PC selection SHALL remain in pc_unit.

Verification (WIDTH=8, STEP=1, RESET_VEC=0x10, RAS_DEPTH=4)
REQ-022 Reset then 3 idle cycles -> pc reads 0x10, 0x11, 0x12, 0x13; rst pulse mid-count -> pc=0x10 immediately.
REQ-023 With pc=0xFF, idle -> pc=0x00; assert stall for 2 cycles -> pc holds 0x00.
REQ-024 branch and jump together, jump_target=0x40, branch_target=0x80 -> pc=0x40.
REQ-025 call from 0x20 to 0x50, then ret -> pc=0x50 then 0x21; ras_count goes 1 then 0.
REQ-026 Five calls from 0x01..0x05 -> ras_overflow pulses once and ras_count=4; four rets -> pc=0x06,0x05,0x04,0x03; fifth ret -> ras_underflow pulses and pc=0x04.
REQ-027 Swap case: ras_count=1 with top=0x31, pc=0x60, call+ret -> pc=0x31, top=0x61, ras_count=1.
